// File: rtl/block_memory_responder_if.sv
// Request/response bundle between the cache controller (master) and the
// block memory responder (slave).
interface block_memory_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [9:0]  req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_write;
   logic [63:0] resp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_write, resp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_write, resp_rdata
   );
endinterface

// File: rtl/block_memory_responder.sv
// Fixed-latency block memory below the cache: 128 x 64-bit blocks, one
// outstanding read (refill) or write (write-back) at a time.
module block_memory_responder #(
   parameter int LATENCY = 2,
   parameter int BLOCKS  = 128
) (
   input  logic                     clk,
   input  logic                     rst_n,
   block_memory_responder_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   logic [1:0]  state_r;
   logic [3:0]  cnt_r;
   logic        wr_r;
   logic [6:0]  idx_r;
   logic [63:0] wdata_r;
   logic        resp_write_r;
   logic [63:0] resp_rdata_r;
   logic [63:0] mem_r [BLOCKS];

   logic        accept_s;
   logic        access_s;
   logic        mem_we_s;

   // Handshake and access-cycle decode from the current state.
   always_comb begin
      accept_s = (state_r == ST_IDLE) && bus.req_valid;
      access_s = (state_r == ST_BUSY) && (cnt_r == 4'd0);
      mem_we_s = access_s && wr_r;
   end

   // Request/response sequencing; the access happens on the last BUSY edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         cnt_r        <= 4'd0;
         wr_r         <= 1'b0;
         idx_r        <= 7'd0;
         wdata_r      <= 64'd0;
         resp_write_r <= 1'b0;
         resp_rdata_r <= 64'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  wr_r    <= bus.req_write;
                  idx_r   <= bus.req_addr[9:3];
                  wdata_r <= bus.req_wdata;
                  cnt_r   <= CNT_LOAD;
                  state_r <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (cnt_r != 4'd0) begin
                  cnt_r <= cnt_r - 4'd1;
               end else begin
                  resp_write_r <= wr_r;
                  resp_rdata_r <= wr_r ? 64'd0 : mem_r[idx_r];
                  state_r      <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus.resp_ready) begin
                  resp_write_r <= 1'b0;
                  resp_rdata_r <= 64'd0;
                  state_r      <= ST_IDLE;
               end
            end
            default: begin
               cnt_r   <= 4'd0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Block storage; reset wipes every block so a write aborted by reset is lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BLOCKS; i++) begin
            mem_r[i] <= 64'd0;
         end
      end else if (mem_we_s) begin
         mem_r[idx_r] <= wdata_r;
      end
   end

   assign bus.req_ready  = (state_r == ST_IDLE);
   assign bus.resp_valid = (state_r == ST_RESP);
   assign bus.resp_write = resp_write_r;
   assign bus.resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_block_memory_responder.sv
// Scoreboard bench for block_memory_responder: functional checks at LATENCY=2
// plus latency/spacing sweeps on LATENCY=1 and LATENCY=15 instances.
module tb_block_memory_responder;

   localparam int LAT = 2;

   typedef struct {
      logic        wr;
      logic [63:0] rd;
   } exp_t;

   logic clk;
   logic rst_n;
   logic sw_rst_n;
   logic sweep_go;
   int   n_cmp;
   int   n_mis;
   exp_t sb_q[$];

   block_memory_responder_if bus();

   block_memory_responder #(.LATENCY(LAT)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Consumed responses are compared against the oldest expectation.
   always @(negedge clk) begin
      #2;
      if (bus.resp_valid && bus.resp_ready) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_resp", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("resp_write", {63'd0, bus.resp_write}, {63'd0, e.wr});
            check_eq("resp_rdata", bus.resp_rdata, e.rd);
         end
      end
   end

   task automatic issue(input logic wr, input logic [9:0] addr, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input int hold);
      int n;
      logic [63:0] held;
      exp_t e;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      n = 0;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("req_ready_wait", {63'd0, (n < 50)}, 64'd1);
      e.wr = wr;
      e.rd = exp_rd;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_addr  = 10'($urandom);
      bus.req_wdata = {$urandom, $urandom};
      n = 0;
      while (!bus.resp_valid && n < 40) begin
         @(posedge clk);
         n++;
         #1;
      end
      check_eq("latency", 64'(n), 64'(LAT));
      held = bus.resp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq("bp_valid", {63'd0, bus.resp_valid}, 64'd1);
         check_eq("bp_req_ready", {63'd0, bus.req_ready}, 64'd0);
         check_eq("bp_rdata", bus.resp_rdata, held);
         if (i == 2) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b1;
            bus.req_addr  = 10'h010;
            bus.req_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
         end else begin
            bus.req_valid = 1'b0;
         end
      end
      bus.req_valid = 1'b0;
      @(negedge clk);
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
      check_eq("post_req_ready", {63'd0, bus.req_ready}, 64'd1);
      check_eq("post_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      check_eq("post_rdata", bus.resp_rdata, 64'd0);
   endtask

   // Latency and request-spacing sweep on independent instances.
   for (genvar g = 0; g < 2; g++) begin : g_sweep
      localparam int SLAT = (g == 0) ? 1 : 15;
      logic done;
      block_memory_responder_if s_if();
      block_memory_responder #(.LATENCY(SLAT)) u_dut (
         .clk   (clk),
         .rst_n (sw_rst_n),
         .bus   (s_if.slave)
      );
      initial begin
         int e, acc1, acc2, rise;
         logic pv;
         done             = 1'b0;
         s_if.req_valid   = 1'b0;
         s_if.req_write   = 1'b0;
         s_if.req_addr    = 10'h000;
         s_if.req_wdata   = 64'd0;
         s_if.resp_ready  = 1'b1;
         wait (sweep_go);
         @(negedge clk);
         s_if.req_valid = 1'b1;
         e = 0; acc1 = -1; acc2 = -1; rise = -1; pv = 1'b0;
         for (int k = 0; k < 3 * (SLAT + 2) + 4; k++) begin
            if (s_if.req_ready) begin
               if (acc1 < 0) acc1 = e + 1;
               else if (acc2 < 0) acc2 = e + 1;
            end
            if (s_if.resp_valid && !pv && rise < 0) rise = e;
            if (s_if.resp_valid) check_eq("sweep_rdata", s_if.resp_rdata, 64'd0);
            pv = s_if.resp_valid;
            @(negedge clk);
            e++;
         end
         check_eq($sformatf("sweep_lat%0d_rise", SLAT), 64'(rise - acc1), 64'(SLAT));
         check_eq($sformatf("sweep_lat%0d_spacing", SLAT), 64'(acc2 - acc1), 64'(SLAT + 2));
         s_if.req_valid = 1'b0;
         done = 1'b1;
      end
   end

   initial begin
      int n;
      n_cmp = 0;
      n_mis = 0;
      rst_n = 1'b0;
      sw_rst_n = 1'b0;
      sweep_go = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = 10'h000;
      bus.req_wdata  = 64'd0;
      bus.resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      @(negedge clk);
      check_eq("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
      check_eq("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      check_eq("rst_resp_write", {63'd0, bus.resp_write}, 64'd0);
      check_eq("rst_resp_rdata", bus.resp_rdata, 64'd0);

      issue(1'b0, 10'h000, 64'd0, 64'd0, 0);
      issue(1'b1, 10'h1A8, 64'hDEADBEEF_12345678, 64'd0, 0);
      issue(1'b0, 10'h1AD, 64'd0, 64'hDEADBEEF_12345678, 0);
      // Backpressure for 5 cycles with a write pulse to 0x010 that must be ignored.
      issue(1'b0, 10'h1A8, 64'd0, 64'hDEADBEEF_12345678, 5);
      issue(1'b0, 10'h010, 64'd0, 64'd0, 0);

      // Reset one edge after accepting a write: the write must not land.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 10'h3F8;
      bus.req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_eq("midbusy_req_ready", {63'd0, bus.req_ready}, 64'd1);
      check_eq("midbusy_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      repeat (4) begin
         @(negedge clk);
         check_eq("midbusy_no_resp", {63'd0, bus.resp_valid}, 64'd0);
      end
      issue(1'b0, 10'h3F8, 64'd0, 64'd0, 0);
      issue(1'b0, 10'h1A8, 64'd0, 64'd0, 0);

      issue(1'b1, 10'h000, 64'h0000_0001_0000_0002, 64'd0, 0);
      issue(1'b1, 10'h3F8, 64'h0000_0003_0000_0004, 64'd0, 0);
      issue(1'b0, 10'h003, 64'd0, 64'h0000_0001_0000_0002, 0);
      issue(1'b0, 10'h3FF, 64'd0, 64'h0000_0003_0000_0004, 0);
      issue(1'b0, 10'h008, 64'd0, 64'd0, 0);

      // Background latency sweep on the LATENCY=1 and LATENCY=15 instances.
      @(negedge clk);
      sw_rst_n = 1'b1;
      @(negedge clk);
      sweep_go = 1'b1;
      n = 0;
      while (!(g_sweep[0].done && g_sweep[1].done) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq("sweep_done", {63'd0, (n < 400)}, 64'd1);

      repeat (2) @(negedge clk);
      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
